mcl65_bus_arbiter: RTL and testbench

//  Generates the CLK0 phase clock for the MCL65 core and shares the 6502 memory bus between the core and one DMA requester.
//  DMA takes the bus only in phase 2 of CPU read cycles; the core is held with READY low, so its read repeats.

---
 rtl/mcl65_bus_arbiter_if.sv | 41 ++++
 rtl/mcl65_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mcl65_bus_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mcl65_bus_arbiter_if.sv
// mcl65_bus_arbiter_if
//   Bundles the MCL65 bus pins, the DMA requester port and the system memory
//   port that meet at the bus arbiter.
//   slave  modport : the arbiter itself. It drives CLK0, READY, the grant and
//                    done handshake, the muxed memory bus and the read data.
//   master modport : the surroundings (core, DMA engine, memory). They drive
//                    the addresses, write data, read/write strobes,
//                    DMA_REQ and MEM_D_IN.
interface mcl65_bus_arbiter_if;
  logic        CLK0;
  logic [15:0] CPU_A;
  logic [7:0]  CPU_D_OUT;
  logic        CPU_RDWR_n;
  logic        CPU_READY;
  logic [7:0]  CPU_D_IN;
  logic        DMA_REQ;
  logic [15:0] DMA_A;
  logic [7:0]  DMA_D_OUT;
  logic        DMA_RDWR_n;
  logic        DMA_GNT;
  logic        DMA_DONE;
  logic [7:0]  DMA_D_IN;
  logic [15:0] MEM_A;
  logic [7:0]  MEM_D_OUT;
  logic        MEM_RDWR_n;
  logic [7:0]  MEM_D_IN;

  modport slave (
    input  CPU_A, CPU_D_OUT, CPU_RDWR_n, DMA_REQ, DMA_A, DMA_D_OUT,
           DMA_RDWR_n, MEM_D_IN,
    output CLK0, CPU_READY, CPU_D_IN, DMA_GNT, DMA_DONE, DMA_D_IN,
           MEM_A, MEM_D_OUT, MEM_RDWR_n
  );

  modport master (
    output CPU_A, CPU_D_OUT, CPU_RDWR_n, DMA_REQ, DMA_A, DMA_D_OUT,
           DMA_RDWR_n, MEM_D_IN,
    input  CLK0, CPU_READY, CPU_D_IN, DMA_GNT, DMA_DONE, DMA_D_IN,
           MEM_A, MEM_D_OUT, MEM_RDWR_n
  );
endinterface

// File: rtl/mcl65_bus_arbiter.sv
// mcl65_bus_arbiter
//   Generates the CLK0 phase clock for the MCL65 core. It also shares the
//   6502-style memory bus between the core and a single DMA requester. The
//   DMA may only take phase 2 of a CPU read cycle. The core is then held
//   with READY low, so its read is simply repeated in the next CLK0 cycle.
// Ports
//   CORE_CLK : core clock, all state updates on its rising edge
//   RESET    : synchronous, active-high reset
//   bus      : mcl65_bus_arbiter_if.slave
//              - CLK0 phase clock (low = phase 1, high = phase 2)
//              - CPU port: CPU_A/CPU_D_OUT/CPU_RDWR_n in, CPU_READY/CPU_D_IN out
//              - DMA port: DMA_REQ/DMA_A/DMA_D_OUT/DMA_RDWR_n in,
//                          DMA_GNT/DMA_DONE/DMA_D_IN out
//              - memory port: MEM_A/MEM_D_OUT/MEM_RDWR_n out, MEM_D_IN in
module mcl65_bus_arbiter #(
  parameter int HALF_PERIOD   = 25,
  parameter int MAX_DMA_BURST = 4,
  parameter int CNT_W         = 8
) (
  input logic               CORE_CLK,
  input logic               RESET,
  mcl65_bus_arbiter_if.slave bus
);

  localparam int BURST_W = $clog2(MAX_DMA_BURST + 1);
  localparam logic [CNT_W-1:0]   CNT_TERM  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DMA_BURST);

  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } own_e;

  logic [CNT_W-1:0]   cnt_r;
  logic               clk0_r;
  own_e               own_r;
  logic               ready_r;
  logic               gnt_r;
  logic               done_r;
  logic [7:0]         dma_d_in_r;
  logic [BURST_W-1:0] burst_r;

  logic               term_s;
  logic               rise_s;
  logic               fall_s;
  logic               grant_ok_s;
  logic [15:0]        mem_a_s;
  logic [7:0]         mem_d_out_s;
  logic               mem_rdwr_n_s;

  // Phase-boundary decode and the DMA admission rule evaluated at RISE.
  always_comb begin
    term_s     = 1'b0;
    rise_s     = 1'b0;
    fall_s     = 1'b0;
    grant_ok_s = 1'b0;
    if (cnt_r == CNT_TERM) begin
      term_s = 1'b1;
      rise_s = ~clk0_r;
      fall_s = clk0_r;
    end else begin
      term_s = 1'b0;
    end
    // The DMA may only steal a read cycle, and only while under the burst cap.
    if (bus.DMA_REQ && bus.CPU_RDWR_n && (burst_r < BURST_MAX)) begin
      grant_ok_s = 1'b1;
    end else begin
      grant_ok_s = 1'b0;
    end
  end

  // Phase counter, CLK0 generation and the CPU/DMA ownership FSM.
  always_ff @(posedge CORE_CLK) begin
    if (RESET) begin
      cnt_r      <= '0;
      clk0_r     <= 1'b0;
      own_r      <= OWN_CPU;
      ready_r    <= 1'b1;
      gnt_r      <= 1'b0;
      done_r     <= 1'b0;
      dma_d_in_r <= 8'h00;
      burst_r    <= '0;
    end else begin
      done_r <= 1'b0;
      if (term_s) begin
        cnt_r  <= '0;
        clk0_r <= ~clk0_r;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1);
      end
      case (own_r)
        OWN_CPU: begin
          if (rise_s) begin
            if (grant_ok_s) begin
              own_r   <= OWN_DMA;
              burst_r <= burst_r + BURST_W'(1);
              ready_r <= 1'b0;
              gnt_r   <= 1'b1;
            end else begin
              // A CPU-owned cycle breaks the burst, so the count restarts.
              ready_r <= 1'b1;
              burst_r <= '0;
            end
          end
        end
        OWN_DMA: begin
          // The committed cycle always completes, even if DMA_REQ dropped.
          if (fall_s) begin
            own_r      <= OWN_CPU;
            gnt_r      <= 1'b0;
            done_r     <= 1'b1;
            dma_d_in_r <= bus.MEM_D_IN;
          end
        end
        default: begin
          own_r <= OWN_CPU;
          gnt_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory bus mux. It is driven from the registered owner, so phase 1 is
  // always the CPU's.
  always_comb begin
    mem_a_s      = bus.CPU_A;
    mem_d_out_s  = bus.CPU_D_OUT;
    mem_rdwr_n_s = bus.CPU_RDWR_n;
    case (own_r)
      OWN_DMA: begin
        mem_a_s      = bus.DMA_A;
        mem_d_out_s  = bus.DMA_D_OUT;
        mem_rdwr_n_s = bus.DMA_RDWR_n;
      end
      OWN_CPU: begin
        mem_a_s      = bus.CPU_A;
        mem_d_out_s  = bus.CPU_D_OUT;
        mem_rdwr_n_s = bus.CPU_RDWR_n;
      end
      default: begin
        mem_a_s      = bus.CPU_A;
        mem_d_out_s  = bus.CPU_D_OUT;
        mem_rdwr_n_s = bus.CPU_RDWR_n;
      end
    endcase
  end

  assign bus.CLK0       = clk0_r;
  assign bus.CPU_READY  = ready_r;
  assign bus.CPU_D_IN   = bus.MEM_D_IN;
  assign bus.DMA_GNT    = gnt_r;
  assign bus.DMA_DONE   = done_r;
  assign bus.DMA_D_IN   = dma_d_in_r;
  assign bus.MEM_A      = mem_a_s;
  assign bus.MEM_D_OUT  = mem_d_out_s;
  assign bus.MEM_RDWR_n = mem_rdwr_n_s;

endmodule

// File: tb/tb_mcl65_bus_arbiter.sv
// tb_mcl65_bus_arbiter
//   Randomized and directed bench for mcl65_bus_arbiter with HALF_PERIOD=4
//   and MAX_DMA_BURST=4. The reference model counts CORE_CLK edges since
//   reset and derives the CLK0 phase from that count by modular arithmetic.
//   It then applies the grant / release rules at the phase boundaries.
module tb_mcl65_bus_arbiter;
  localparam int HP   = 4;
  localparam int MAXB = 4;

  logic CORE_CLK = 1'b0;
  logic RESET    = 1'b1;
  mcl65_bus_arbiter_if bus ();

  mcl65_bus_arbiter #(.HALF_PERIOD(HP), .MAX_DMA_BURST(MAXB), .CNT_W(8)) dut (
    .CORE_CLK (CORE_CLK),
    .RESET    (RESET),
    .bus      (bus)
  );

  always #5 CORE_CLK = ~CORE_CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  int         m_k;
  int         m_streak;
  logic       m_ready;
  logic       m_gnt;
  logic       m_done;
  logic [7:0] m_dmain;

  // Model: the edge count since reset gives the phase; the grant rules act at boundaries.
  always @(posedge CORE_CLK) begin
    if (RESET) begin
      m_k      <= 0;
      m_streak <= 0;
      m_ready  <= 1'b1;
      m_gnt    <= 1'b0;
      m_done   <= 1'b0;
      m_dmain  <= 8'h00;
    end else begin
      m_k    <= m_k + 1;
      m_done <= 1'b0;
      if ((m_k + 1) % (2 * HP) == HP) begin
        if (bus.DMA_REQ && bus.CPU_RDWR_n && m_streak < MAXB) begin
          m_gnt    <= 1'b1;
          m_ready  <= 1'b0;
          m_streak <= m_streak + 1;
        end else begin
          m_ready  <= 1'b1;
          m_streak <= 0;
        end
      end else if ((m_k + 1) % (2 * HP) == 0 && m_gnt) begin
        m_gnt   <= 1'b0;
        m_done  <= 1'b1;
        m_dmain <= bus.MEM_D_IN;
      end
    end
  end

  // Compare the DUT against the model on every falling edge once out of reset.
  always @(negedge CORE_CLK) begin
    if (chk_en) begin
      chk("clk0",     32'(bus.CLK0),      32'(((m_k % (2 * HP)) >= HP) ? 1 : 0));
      chk("ready",    32'(bus.CPU_READY), 32'(m_ready));
      chk("gnt",      32'(bus.DMA_GNT),   32'(m_gnt));
      chk("done",     32'(bus.DMA_DONE),  32'(m_done));
      chk("dma_d_in", 32'(bus.DMA_D_IN),  32'(m_dmain));
      chk("mem_a",    32'(bus.MEM_A),      32'(m_gnt ? bus.DMA_A : bus.CPU_A));
      chk("mem_dout", 32'(bus.MEM_D_OUT),  32'(m_gnt ? bus.DMA_D_OUT : bus.CPU_D_OUT));
      chk("mem_rw",   32'(bus.MEM_RDWR_n), 32'(m_gnt ? bus.DMA_RDWR_n : bus.CPU_RDWR_n));
      chk("cpu_d_in", 32'(bus.CPU_D_IN),   32'(bus.MEM_D_IN));
    end
  end

  // One CORE_CLK cycle. The bench acts 2 time units after the falling edge.
  task automatic tick();
    @(posedge CORE_CLK);
    @(negedge CORE_CLK);
    #2;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic wait_gnt(input int budget, input string name);
    int n;
    n = 0;
    while (!bus.DMA_GNT && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.DMA_GNT), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!bus.DMA_DONE && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.DMA_DONE), 32'd1);
  endtask

  initial begin
    int cnt;
    int hi;
    bit bad;
    bus.CPU_A      = 16'h1234;
    bus.CPU_D_OUT  = 8'h00;
    bus.CPU_RDWR_n = 1'b1;
    bus.DMA_REQ    = 1'b0;
    bus.DMA_A      = 16'h0400;
    bus.DMA_D_OUT  = 8'h00;
    bus.DMA_RDWR_n = 1'b1;
    bus.MEM_D_IN   = 8'h5A;
    @(negedge CORE_CLK);
    #2;
    do_reset();
    chk_en = 1'b1;

    // 1: CLK0 stays low for 4 clocks, then high for 4, with READY=1 and no grant.
    chk("rst_clk0", 32'(bus.CLK0), 32'd0);
    chk("rst_ready", 32'(bus.CPU_READY), 32'd1);
    chk("rst_gnt", 32'(bus.DMA_GNT), 32'd0);
    chk("rst_dmain", 32'(bus.DMA_D_IN), 32'h00);
    chk("rst_mem_a", 32'(bus.MEM_A), 32'h1234);
    hi = 0;
    bad = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (bus.CLK0 !== ((((i / 4) % 2) == 1) ? 1'b1 : 1'b0)) bad = 1'b1;
      if (bus.CLK0 === 1'b1) hi++;
    end
    chk("clk0_pattern_bad", 32'(bad), 32'd0);
    chk("clk0_high_count", 32'(hi), 32'd8);

    // 2: A DMA read of 0x0400 is interleaved into a CPU read of 0x1234.
    do_reset();
    bus.DMA_REQ = 1'b1;
    wait_gnt(20, "t2_gnt");
    chk("t2_ready", 32'(bus.CPU_READY), 32'd0);
    chk("t2_mem_a", 32'(bus.MEM_A), 32'h0400);
    bus.DMA_REQ = 1'b0;
    wait_done(20, "t2_done");
    chk("t2_dmain", 32'(bus.DMA_D_IN), 32'h5A);
    chk("t2_gnt_off", 32'(bus.DMA_GNT), 32'd0);
    chk("t2_mem_a_cpu", 32'(bus.MEM_A), 32'h1234);

    // 3: A CPU write cycle wins over DMA_REQ.
    do_reset();
    bus.CPU_RDWR_n = 1'b0;
    bus.DMA_REQ    = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.DMA_GNT !== 1'b0 || bus.CPU_READY !== 1'b1) bad = 1'b1;
    end
    chk("t3_no_grant_on_write", 32'(bad), 32'd0);
    bus.CPU_RDWR_n = 1'b1;
    wait_gnt(20, "t3_gnt_after_read");

    // 4: With REQ held, 4 DMA cycles run, then one CPU cycle, then DMA resumes.
    do_reset();
    bus.DMA_REQ = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (bus.DMA_DONE === 1'b1) cnt++;
      if (i == 40) chk("t4_cpu_slot_ready", 32'(bus.CPU_READY), 32'd1);
    end
    chk("t4_burst_done_count", 32'(cnt), 32'd4);
    for (int i = 46; i <= 52; i++) begin
      tick();
      if (bus.DMA_DONE === 1'b1) cnt++;
    end
    chk("t4_resume_done_count", 32'(cnt), 32'd5);

    // 5: A DMA write drives the memory bus during the granted phase 2.
    do_reset();
    bus.DMA_A      = 16'h2000;
    bus.DMA_D_OUT  = 8'hA5;
    bus.DMA_RDWR_n = 1'b0;
    bus.DMA_REQ    = 1'b1;
    wait_gnt(20, "t5_gnt");
    chk("t5_mem_rw", 32'(bus.MEM_RDWR_n), 32'd0);
    chk("t5_mem_dout", 32'(bus.MEM_D_OUT), 32'hA5);
    chk("t5_mem_a", 32'(bus.MEM_A), 32'h2000);

    // 6: A reset in the middle of a grant aborts the cycle without DONE.
    tick();
    do_reset();
    chk("t6_gnt", 32'(bus.DMA_GNT), 32'd0);
    chk("t6_ready", 32'(bus.CPU_READY), 32'd1);
    chk("t6_clk0", 32'(bus.CLK0), 32'd0);
    chk("t6_done", 32'(bus.DMA_DONE), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.DMA_DONE === 1'b1) bad = 1'b1;
    end
    chk("t6_no_done_after_abort", 32'(bad), 32'd0);

    // Random traffic, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bus.CPU_A      = 16'($urandom);
      bus.CPU_D_OUT  = 8'($urandom);
      bus.CPU_RDWR_n = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
      bus.DMA_REQ    = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
      bus.DMA_A      = 16'($urandom);
      bus.DMA_D_OUT  = 8'($urandom);
      bus.DMA_RDWR_n = 1'($urandom);
      bus.MEM_D_IN   = 8'($urandom);
      RESET          = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
      tick();
    end
    RESET = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
